// File: rtl/amb_denetleyici_pkg.sv
// Shared widths and state encoding for the ALU issue/write-back controller.
package amb_denetleyici_pkg;

  localparam int UOP_AMB_BIT = 5;

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    CALIS = 2'd1,
    YAZ   = 2'd2
  } durum_e;

endpackage

// File: rtl/amb_denetleyici.sv
// Issues one micro-op at a time to a neighbouring ALU, holds the operands until the
// ALU reports completion, then presents the result to write-back.
module amb_denetleyici
  import amb_denetleyici_pkg::*;
#(
  parameter int VERI_BIT  = 32,
  parameter int HEDEF_BIT = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [UOP_AMB_BIT-1:0] istek_kod_i,
  input  logic [VERI_BIT-1:0]    istek_islec1_i,
  input  logic [VERI_BIT-1:0]    istek_islec2_i,
  input  logic [HEDEF_BIT-1:0]   istek_hedef_i,
  input  logic                   istek_gecerli_i,
  output logic                   istek_hazir_o,
  output logic [UOP_AMB_BIT-1:0] amb_kod_o,
  output logic                   amb_kod_gecerli_o,
  output logic [VERI_BIT-1:0]    amb_islec1_o,
  output logic [VERI_BIT-1:0]    amb_islec2_o,
  input  logic [VERI_BIT-1:0]    amb_sonuc_i,
  input  logic                   amb_gecerli_i,
  output logic [VERI_BIT-1:0]    sonuc_o,
  output logic [HEDEF_BIT-1:0]   sonuc_hedef_o,
  output logic                   sonuc_gecerli_o,
  input  logic                   sonuc_hazir_i,
  input  logic                   temizle_i,
  output logic [31:0]            islem_sayisi_o
);

  durum_e                 r_durum;
  logic [UOP_AMB_BIT-1:0] r_kod;
  logic [VERI_BIT-1:0]    r_islec1;
  logic [VERI_BIT-1:0]    r_islec2;
  logic [VERI_BIT-1:0]    r_sonuc;
  logic [HEDEF_BIT-1:0]   r_hedef;
  logic                   r_kod_gecerli;
  logic                   r_sonuc_gecerli;
  logic [31:0]            r_sayac;
  logic                   w_kabul;

  // Ready is combinational so a drained result and the next request share one edge.
  assign istek_hazir_o = !temizle_i &&
                         ((r_durum == BOS) || ((r_durum == YAZ) && sonuc_hazir_i));
  assign w_kabul       = istek_hazir_o && istek_gecerli_i;

  // NOTE: every register here uses <= so all state advances together on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum         <= BOS;
      r_kod           <= '0;
      r_islec1        <= '0;
      r_islec2        <= '0;
      r_sonuc         <= '0;
      r_hedef         <= '0;
      r_kod_gecerli   <= 1'b0;
      r_sonuc_gecerli <= 1'b0;
      r_sayac         <= '0;
    end else if (temizle_i) begin
      r_durum         <= BOS;
      r_kod_gecerli   <= 1'b0;
      r_sonuc_gecerli <= 1'b0;
    end else if (w_kabul) begin
      // Reachable only from BOS or from a drained YAZ.
      r_durum         <= CALIS;
      r_kod           <= istek_kod_i;
      r_islec1        <= istek_islec1_i;
      r_islec2        <= istek_islec2_i;
      r_hedef         <= istek_hedef_i;
      r_kod_gecerli   <= 1'b1;
      r_sonuc_gecerli <= 1'b0;
    end else begin
      case (r_durum)
        CALIS: begin
          if (amb_gecerli_i) begin
            r_durum         <= YAZ;
            r_sonuc         <= amb_sonuc_i;
            r_kod_gecerli   <= 1'b0;
            r_sonuc_gecerli <= 1'b1;
            r_sayac         <= r_sayac + 32'd1;
          end
        end
        YAZ: begin
          if (sonuc_hazir_i) begin
            r_durum         <= BOS;
            r_sonuc_gecerli <= 1'b0;
          end
        end
        default: begin
          r_durum <= BOS;
        end
      endcase
    end
  end

  assign amb_kod_o         = r_kod;
  assign amb_islec1_o      = r_islec1;
  assign amb_islec2_o      = r_islec2;
  assign amb_kod_gecerli_o = r_kod_gecerli;
  assign sonuc_o           = r_sonuc;
  assign sonuc_hedef_o     = r_hedef;
  assign sonuc_gecerli_o   = r_sonuc_gecerli;
  assign islem_sayisi_o    = r_sayac;

endmodule

// File: tb/tb_amb_denetleyici.sv
// Directed bench for amb_denetleyici with a variable-latency ALU model beside the DUT.
module tb_amb_denetleyici;
  import amb_denetleyici_pkg::*;

  localparam logic [4:0] UOP_ADD  = 5'd0;
  localparam logic [4:0] UOP_MUL  = 5'd1;
  localparam logic [4:0] UOP_DIV  = 5'd2;
  localparam logic [4:0] UOP_DIVU = 5'd3;
  localparam logic [4:0] UOP_REM  = 5'd4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  istek_kod_i;
  logic [31:0] istek_islec1_i, istek_islec2_i;
  logic [4:0]  istek_hedef_i;
  logic        istek_gecerli_i;
  logic        istek_hazir_o;
  logic [4:0]  amb_kod_o;
  logic        amb_kod_gecerli_o;
  logic [31:0] amb_islec1_o, amb_islec2_o;
  logic [31:0] amb_sonuc_i;
  logic        amb_gecerli_i;
  logic [31:0] sonuc_o;
  logic [4:0]  sonuc_hedef_o;
  logic        sonuc_gecerli_o;
  logic        sonuc_hazir_i;
  logic        temizle_i;
  logic [31:0] islem_sayisi_o;

  amb_denetleyici #(.VERI_BIT(32), .HEDEF_BIT(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .istek_kod_i(istek_kod_i), .istek_islec1_i(istek_islec1_i),
    .istek_islec2_i(istek_islec2_i), .istek_hedef_i(istek_hedef_i),
    .istek_gecerli_i(istek_gecerli_i), .istek_hazir_o(istek_hazir_o),
    .amb_kod_o(amb_kod_o), .amb_kod_gecerli_o(amb_kod_gecerli_o),
    .amb_islec1_o(amb_islec1_o), .amb_islec2_o(amb_islec2_o),
    .amb_sonuc_i(amb_sonuc_i), .amb_gecerli_i(amb_gecerli_i),
    .sonuc_o(sonuc_o), .sonuc_hedef_o(sonuc_hedef_o), .sonuc_gecerli_o(sonuc_gecerli_o),
    .sonuc_hazir_i(sonuc_hazir_i), .temizle_i(temizle_i), .islem_sayisi_o(islem_sayisi_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string ad, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", ad, act, exp);
    end
  endtask

  // ALU model: registered result, valid on the lat-th edge with code-valid high,
  // cleared as soon as code-valid drops.
  int          alu_lat = 1;
  int          alu_cnt = 0;
  function automatic logic [31:0] alu_f(input logic [4:0] k, input logic [31:0] a, input logic [31:0] b);
    case (k)
      UOP_ADD:  return a + b;
      UOP_MUL:  return a * b;
      UOP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
      UOP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      UOP_REM:  return (b == 0) ? a : 32'($signed(a) % $signed(b));
      default:  return 32'h0;
    endcase
  endfunction

  always @(posedge clk_i) begin
    if (rst_i || !amb_kod_gecerli_o) begin
      alu_cnt       <= 0;
      amb_gecerli_i <= 1'b0;
    end else if (!amb_gecerli_i) begin
      if (alu_cnt == alu_lat - 1) begin
        amb_gecerli_i <= 1'b1;
        amb_sonuc_i   <= alu_f(amb_kod_o, amb_islec1_o, amb_islec2_o);
      end else begin
        alu_cnt <= alu_cnt + 1;
      end
    end
  end

  // Write-back monitor used by the back-to-back sequence.
  bit          mon_en = 0;
  logic [31:0] got_s[$];
  logic [4:0]  got_h[$];
  always @(negedge clk_i) begin
    if (mon_en && sonuc_gecerli_o && sonuc_hazir_i) begin
      got_s.push_back(sonuc_o);
      got_h.push_back(sonuc_hedef_o);
    end
  end

  typedef struct {
    string       ad;
    logic [4:0]  kod;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  hedef;
    int          lat;
    logic [31:0] bek;
  } vek_t;

  vek_t vek[7];

  // Starts from BOS at #1 after an edge; returns at #1 after the edge that enters YAZ.
  task automatic islem(input vek_t v, input bit serbest);
    int  k;
    bit  stabil;
    alu_lat         = v.lat;
    istek_kod_i     = v.kod;
    istek_islec1_i  = v.a;
    istek_islec2_i  = v.b;
    istek_hedef_i   = v.hedef;
    istek_gecerli_i = 1'b1;
    #1;
    check({v.ad, "_istek_hazir"}, 32'(istek_hazir_o), 32'd1);
    @(posedge clk_i); #1;
    istek_gecerli_i = 1'b0;
    istek_islec1_i  = 32'hDEAD_BEEF;
    istek_islec2_i  = 32'hDEAD_BEEF;
    k = 0;
    stabil = 1;
    while (!sonuc_gecerli_o && k < 200) begin
      if (!(amb_kod_gecerli_o && amb_kod_o == v.kod && amb_islec1_o == v.a && amb_islec2_o == v.b))
        stabil = 0;
      @(posedge clk_i); #1;
      k++;
    end
    exp_cnt++;
    check({v.ad, "_islec_stabil"}, 32'(stabil), 32'd1);
    check({v.ad, "_gecikme"}, 32'(k), 32'(v.lat + 1));
    check({v.ad, "_sonuc"}, sonuc_o, v.bek);
    check({v.ad, "_hedef"}, 32'(sonuc_hedef_o), 32'(v.hedef));
    check({v.ad, "_kod_gecerli_yaz"}, 32'(amb_kod_gecerli_o), 32'd0);
    check({v.ad, "_sayac"}, islem_sayisi_o, 32'(exp_cnt));
    if (serbest) begin
      @(posedge clk_i); #1;
      check({v.ad, "_tek_cevrim"}, 32'(sonuc_gecerli_o), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vek[0] = '{"add_5_7",   UOP_ADD,  32'd5,   32'd7, 5'd3,  1,  32'd12};
    vek[1] = '{"div_100_7", UOP_DIV,  32'd100, 32'd7, 5'd4,  34, 32'd14};
    vek[2] = '{"divu_x_0",  UOP_DIVU, 32'd9,   32'd0, 5'd5,  34, 32'hFFFF_FFFF};
    vek[3] = '{"div_neg",   UOP_DIV,  -32'sd100, 32'd7, 5'd6, 3, 32'hFFFF_FFF2};
    vek[4] = '{"rem_100_7", UOP_REM,  32'd100, 32'd7, 5'd7,  5,  32'd2};
    vek[5] = '{"hedef_0",   UOP_ADD,  32'hFFFF_FFFF, 32'd2, 5'd0, 1, 32'd1};
    vek[6] = '{"mul_6_7",   UOP_MUL,  32'd6,   32'd7, 5'd31, 2,  32'd42};

    rst_i = 1; temizle_i = 0; sonuc_hazir_i = 1; istek_gecerli_i = 0;
    istek_kod_i = '0; istek_islec1_i = '0; istek_islec2_i = '0; istek_hedef_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_istek_hazir", 32'(istek_hazir_o), 32'd1);
    check("rst_kod_gecerli", 32'(amb_kod_gecerli_o), 32'd0);
    check("rst_sonuc_gecerli", 32'(sonuc_gecerli_o), 32'd0);
    check("rst_sonuc", sonuc_o, 32'd0);
    check("rst_hedef", 32'(sonuc_hedef_o), 32'd0);
    check("rst_sayac", islem_sayisi_o, 32'd0);
    rst_i = 0;
    @(posedge clk_i); #1;

    foreach (vek[i]) islem(vek[i], 1'b1);

    // Write-back stalls for five cycles; result and destination must hold.
    begin
      bit tutuldu;
      vek_t m;
      m = '{"mul_stall", UOP_MUL, 32'd3, 32'd4, 5'd9, 2, 32'd12};
      sonuc_hazir_i = 0;
      islem(m, 1'b0);
      tutuldu = 1;
      repeat (5) begin
        if (!(sonuc_gecerli_o && sonuc_o == 32'd12 && sonuc_hedef_o == 5'd9 && !istek_hazir_o))
          tutuldu = 0;
        @(posedge clk_i); #1;
      end
      check("mul_stall_held", 32'(tutuldu), 32'd1);
      check("mul_stall_valid_after_5", 32'(sonuc_gecerli_o), 32'd1);
      sonuc_hazir_i = 1;
      #1;
      check("mul_stall_release_hazir", 32'(istek_hazir_o), 32'd1);
      @(posedge clk_i); #1;
      check("mul_stall_released", 32'(sonuc_gecerli_o), 32'd0);
    end

    // Flush during a REM, with a request offered on the same cycle.
    begin
      bit goruldu;
      alu_lat = 10;
      istek_kod_i = UOP_REM; istek_islec1_i = 32'd50; istek_islec2_i = 32'd6;
      istek_hedef_i = 5'd2; istek_gecerli_i = 1;
      @(posedge clk_i); #1;
      istek_gecerli_i = 0;
      repeat (3) @(posedge clk_i);
      #1;
      check("flush_calis_kod_gecerli", 32'(amb_kod_gecerli_o), 32'd1);
      temizle_i = 1;
      istek_kod_i = UOP_ADD; istek_islec1_i = 32'd1; istek_islec2_i = 32'd1;
      istek_gecerli_i = 1;
      #1;
      check("flush_istek_hazir", 32'(istek_hazir_o), 32'd0);
      @(posedge clk_i); #1;
      temizle_i = 0;
      istek_gecerli_i = 0;
      check("flush_kod_gecerli_next", 32'(amb_kod_gecerli_o), 32'd0);
      check("flush_sonuc_gecerli", 32'(sonuc_gecerli_o), 32'd0);
      goruldu = 0;
      repeat (15) begin
        @(posedge clk_i); #1;
        if (sonuc_gecerli_o || amb_kod_gecerli_o) goruldu = 1;
      end
      check("flush_no_activity", 32'(goruldu), 32'd0);
      check("flush_sayac", islem_sayisi_o, 32'(exp_cnt));
    end

    // Ten back-to-back ADDs with write-back always ready.
    begin
      int acc[10];
      int guard;
      bit zaman_asimi;
      alu_lat = 1;
      mon_en = 1;
      zaman_asimi = 0;
      for (int i = 0; i < 10; i++) begin
        istek_kod_i = UOP_ADD;
        istek_islec1_i = 32'(i * 10);
        istek_islec2_i = 32'(i + 1);
        istek_hedef_i = 5'(i + 1);
        istek_gecerli_i = 1;
        guard = 0;
        #1;
        while (!istek_hazir_o && guard < 20) begin
          @(posedge clk_i); #1;
          guard++;
        end
        if (guard >= 20) zaman_asimi = 1;
        acc[i] = cyc;
        @(posedge clk_i); #1;
      end
      istek_gecerli_i = 0;
      repeat (5) @(posedge clk_i);
      #1;
      mon_en = 0;
      check("b2b_timeout", 32'(zaman_asimi), 32'd0);
      for (int i = 1; i < 10; i++)
        check($sformatf("b2b_issue_gap_%0d", i), 32'(acc[i] - acc[i-1]), 32'd3);
      check("b2b_count", 32'(got_s.size()), 32'd10);
      for (int i = 0; i < 10 && i < got_s.size(); i++) begin
        check($sformatf("b2b_sonuc_%0d", i), got_s[i], 32'(i * 10 + i + 1));
        check($sformatf("b2b_hedef_%0d", i), 32'(got_h[i]), 32'(i + 1));
      end
      exp_cnt += 10;
      check("b2b_sayac", islem_sayisi_o, 32'(exp_cnt));
    end

    // Reset in the middle of a long operation.
    begin
      bit goruldu;
      alu_lat = 10;
      istek_kod_i = UOP_ADD; istek_islec1_i = 32'd77; istek_islec2_i = 32'd1;
      istek_hedef_i = 5'd12; istek_gecerli_i = 1;
      @(posedge clk_i); #1;
      istek_gecerli_i = 0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1;
      @(posedge clk_i); #1;
      rst_i = 0;
      exp_cnt = 0;
      check("mrst_istek_hazir", 32'(istek_hazir_o), 32'd1);
      check("mrst_kod_gecerli", 32'(amb_kod_gecerli_o), 32'd0);
      check("mrst_sonuc_gecerli", 32'(sonuc_gecerli_o), 32'd0);
      check("mrst_sonuc", sonuc_o, 32'd0);
      check("mrst_hedef", 32'(sonuc_hedef_o), 32'd0);
      check("mrst_islec1", amb_islec1_o, 32'd0);
      check("mrst_sayac", islem_sayisi_o, 32'd0);
      goruldu = 0;
      repeat (15) begin
        @(posedge clk_i); #1;
        if (sonuc_gecerli_o) goruldu = 1;
      end
      check("mrst_no_result", 32'(goruldu), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
